// File: rtl/shift_sequencer.sv
// shift_sequencer: paces a parallel word out over a serial shift-register
// control interface (shift-enable / direction / serial-in), one bit per SHIFT
// cycle with DIV idle cycles between shifts, then pulses done.
// Optional receive capture of the shift register's outgoing bit is enabled
// by defining SHIFT_SEQUENCER_RX_CAPTURE_EN.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic             cmd_dir,
  input  logic [DIV_W-1:0] cmd_div,
  input  logic             abort,
  output logic             sr_shift_en,
  output logic             sr_dir,
  output logic             sr_serial_in,
  output logic             busy,
  output logic             done,
`ifdef SHIFT_SEQUENCER_RX_CAPTURE_EN
  input  logic             sr_serial_out,
  output logic [WIDTH-1:0] rx_data,
`endif
  output logic [CNT_W-1:0] bit_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

  logic [1:0]       state;
  logic [WIDTH-1:0] hold;
  logic [CNT_W-1:0] len_q;
  logic             dir_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] wcnt;
  logic [CNT_W-1:0] cnt_q;
  logic             last_bit;
  logic [CNT_W-1:0] eff_len;
  logic             cur_bit;
  logic [CNT_W-1:0] cnt_inc;

  // A zero or oversize length means a full word.
  always_comb begin
    eff_len = cmd_len;
    if (cmd_len == '0 || cmd_len > WIDTH_C) eff_len = WIDTH_C;
  end

  assign cur_bit = dir_q ? hold[WIDTH-1] : hold[0];
  assign cnt_inc = cnt_q + CNT_W'(1);

  // Outputs decoded purely from registered state and datapath flops.
  always_comb begin
    cmd_ready    = (state == S_IDLE);
    busy         = (state != S_IDLE);
    done         = (state == S_DONE);
    sr_shift_en  = (state == S_SHIFT);
    sr_dir       = (state != S_IDLE) ? dir_q : 1'b0;
    sr_serial_in = 1'b0;
    if (state == S_SHIFT)     sr_serial_in = cur_bit;
    else if (state != S_IDLE) sr_serial_in = last_bit;
    bit_cnt      = cnt_q;
  end

`ifdef SHIFT_SEQUENCER_RX_CAPTURE_EN
  logic [WIDTH-1:0] rx_q;
  assign rx_data = rx_q;

  // Receive capture: shift the returned bit in the same direction as the send.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_q <= '0;
    end else if (state == S_IDLE && cmd_valid) begin
      rx_q <= '0;
    end else if (state == S_SHIFT) begin
      if (dir_q) rx_q <= {rx_q[WIDTH-2:0], sr_serial_out};
      else       rx_q <= {sr_serial_out, rx_q[WIDTH-1:1]};
    end
  end
`endif

  // Sequencer FSM and send datapath; abort and reset both land in IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      hold     <= '0;
      len_q    <= '0;
      dir_q    <= 1'b0;
      div_q    <= '0;
      wcnt     <= '0;
      cnt_q    <= '0;
      last_bit <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            hold     <= cmd_data;
            len_q    <= eff_len;
            dir_q    <= cmd_dir;
            div_q    <= cmd_div;
            cnt_q    <= '0;
            last_bit <= 1'b0;
            state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // The shift presented this cycle happens even when aborting.
          if (dir_q) hold <= {hold[WIDTH-2:0], 1'b0};
          else       hold <= {1'b0, hold[WIDTH-1:1]};
          last_bit <= cur_bit;
          if (abort) begin
            cnt_q <= '0;
            state <= S_IDLE;
          end else begin
            cnt_q <= cnt_inc;
            if (cnt_inc == len_q) begin
              state <= S_DONE;
            end else if (div_q == '0) begin
              state <= S_SHIFT;
            end else begin
              wcnt  <= div_q - DIV_W'(1);
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (abort) begin
            cnt_q <= '0;
            state <= S_IDLE;
          end else if (wcnt == '0) begin
            state <= S_SHIFT;
          end else begin
            wcnt <= wcnt - DIV_W'(1);
          end
        end
        default: begin
          // DONE: bit_cnt held through this cycle, cleared entering IDLE.
          cnt_q <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed table, abort/reset sequences and
// randomized commands checked against a cycle-timing model derived from the
// command fields. Define SHIFT_SEQUENCER_RX_CAPTURE_EN to include rx checks.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_data = '0;
  logic [3:0] cmd_len = '0;
  logic       cmd_dir = 1'b0;
  logic [3:0] cmd_div = '0;
  logic       abort = 1'b0;
  logic       sr_shift_en, sr_dir, sr_serial_in, busy, done;
  logic [3:0] bit_cnt;
`ifdef SHIFT_SEQUENCER_RX_CAPTURE_EN
  logic       sr_serial_out;
  logic [7:0] rx_data;
  assign sr_serial_out = sr_serial_in;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(8), .CNT_W(4), .DIV_W(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_len(cmd_len), .cmd_dir(cmd_dir), .cmd_div(cmd_div), .abort(abort),
    .sr_shift_en(sr_shift_en), .sr_dir(sr_dir), .sr_serial_in(sr_serial_in),
    .busy(busy), .done(done),
`ifdef SHIFT_SEQUENCER_RX_CAPTURE_EN
    .sr_serial_out(sr_serial_out), .rx_data(rx_data),
`endif
    .bit_cnt(bit_cnt)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_en"}, sr_shift_en, 0);
    chk({tag, "_bitcnt"}, bit_cnt, 0);
  endtask

  // Runs one command from IDLE (called at a negedge) and checks every cycle
  // against timing derived from len/div: shift k happens in cycle
  // 1 + k*(div+1) after the handshake, done in cycle L+(L-1)*div+1.
  task automatic exec(input logic [7:0] d, input logic [3:0] l, input logic dr,
                      input logic [3:0] dv, input bit busy_valid, input bit ab_with,
                      output logic [7:0] seq, output logic [3:0] reg4);
    int L, T, k, dvi, n;
    logic exp_en, eb;
    logic [7:0] exp_rx;
    dvi = int'(dv);
    L = (l == 0 || l > 8) ? 8 : int'(l);
    T = L + (L - 1) * dvi;
    seq = '0;
    reg4 = '0;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    chk("ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_data = d; cmd_len = l; cmd_dir = dr; cmd_div = dv;
    abort = ab_with;
    @(posedge clk);
    for (int c = 1; c <= T + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        abort = 1'b0;
        if (busy_valid) cmd_data = ~d;
        else cmd_valid = 1'b0;
      end
      chk("busy", busy, 1);
      chk("ready_busy", cmd_ready, 0);
      chk("sr_dir", sr_dir, dr);
      if (c <= T) begin
        exp_en = ((c - 1) % (dvi + 1)) == 0;
        chk("shift_en", sr_shift_en, exp_en);
        chk("done_early", done, 0);
        if (exp_en) begin
          k = (c - 1) / (dvi + 1);
          eb = dr ? d[7 - k] : d[k];
          chk("serial_in", sr_serial_in, eb);
          seq = {seq[6:0], sr_serial_in};
          reg4 = dr ? {reg4[2:0], sr_serial_in} : {sr_serial_in, reg4[3:1]};
        end
      end else begin
        chk("done", done, 1);
        chk("shift_en_done", sr_shift_en, 0);
        chk("bitcnt_done", bit_cnt, L);
`ifdef SHIFT_SEQUENCER_RX_CAPTURE_EN
        exp_rx = dr ? (d >> (8 - L)) : (d << (8 - L));
        chk("rx_data", rx_data, exp_rx);
`endif
        if (busy_valid) cmd_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk_idle("after");
    if (busy_valid) begin
      @(negedge clk);
      chk("ignored_cmd", busy, 0);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic [3:0] l;
    logic       dr;
    logic [3:0] dv;
    logic [7:0] seq;
    logic [3:0] r4;
    bit         bv;
  } vec_t;

  vec_t tbl[4];

  initial begin
    logic [7:0] seq;
    logic [3:0] r4;
    tbl[0] = '{8'hB0, 4'd4, 1'b1, 4'd0, 8'h0B, 4'b1011, 1'b0};
    tbl[1] = '{8'h0D, 4'd4, 1'b0, 4'd0, 8'h0B, 4'b1101, 1'b0};
    tbl[2] = '{8'hB0, 4'd4, 1'b1, 4'd2, 8'h0B, 4'b1011, 1'b1};
    tbl[3] = '{8'hA5, 4'd0, 1'b1, 4'd0, 8'hA5, 4'b0101, 1'b0};

    // Reset state.
    repeat (3) @(negedge clk);
    chk_idle("reset");
    chk("reset_dir", sr_dir, 0);
    chk("reset_si", sr_serial_in, 0);
    reset = 1'b1;
    @(negedge clk);

    // Directed table.
    foreach (tbl[i]) begin
      exec(tbl[i].d, tbl[i].l, tbl[i].dr, tbl[i].dv, tbl[i].bv, 1'b0, seq, r4);
      chk($sformatf("tbl%0d_seq", i), seq, tbl[i].seq);
      chk($sformatf("tbl%0d_reg4", i), r4, tbl[i].r4);
    end

    // Abort in the WAIT after the 2nd shift.
    cmd_valid = 1'b1; cmd_data = 8'hB0; cmd_len = 4'd4; cmd_dir = 1'b1; cmd_div = 4'd2;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_pre_wait", sr_shift_en, 0);
    chk("abort_pre_cnt", bit_cnt, 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_idle("abort");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_quiet_en", sr_shift_en, 0);
      chk("abort_quiet_done", done, 0);
    end
    exec(8'h3C, 4'd6, 1'b0, 4'd1, 1'b0, 1'b0, seq, r4);

    // Abort in IDLE together with a command: command is accepted.
    exec(8'h96, 4'd5, 1'b1, 4'd0, 1'b0, 1'b1, seq, r4);

    // Reset (with abort also high) during SHIFT of a full-width transfer.
    cmd_valid = 1'b1; cmd_data = 8'hE7; cmd_len = 4'd8; cmd_dir = 1'b1; cmd_div = 4'd0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_en", sr_shift_en, 1);
    reset = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    chk_idle("midrst");
    chk("midrst_dir", sr_dir, 0);
    chk("midrst_si", sr_serial_in, 0);
    reset = 1'b1;
    abort = 1'b0;
    @(negedge clk);
    chk_idle("post_rst");

`ifdef SHIFT_SEQUENCER_RX_CAPTURE_EN
    chk("rx_after_reset", rx_data, 0);
    exec(8'hC3, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, seq, r4);
`endif

    // Randomized commands.
    for (int i = 0; i < 40; i++) begin
      exec(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom),
           4'($urandom_range(0, 3)), 1'b0, 1'b0, seq, r4);
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
